// File: rtl/s_csub_pkg.sv
// Shared constants and types for the two-stage pipelined signed subtractor.
package s_csub_pkg;

  localparam int unsigned S_CSUB_WIDTH = 24;
  localparam int unsigned S_CSUB_SPLIT = 12;

  typedef logic signed [S_CSUB_WIDTH-1:0] s_csub_word_t;

  localparam s_csub_word_t SAT_MAX = {1'b0, {(S_CSUB_WIDTH-1){1'b1}}};
  localparam s_csub_word_t SAT_MIN = {1'b1, {(S_CSUB_WIDTH-1){1'b0}}};

  // Stage-1 payload layout for the default WIDTH/SPLIT configuration.
  typedef struct packed {
    logic [S_CSUB_SPLIT-1:0]              lo;
    logic                                 c1;
    logic [S_CSUB_WIDTH-S_CSUB_SPLIT-1:0] a_hi;
    logic [S_CSUB_WIDTH-S_CSUB_SPLIT-1:0] nb_hi;
    logic                                 a_msb;
    logic                                 b_msb;
  } s_csub_stage1_t;

endpackage

// File: rtl/s_csub_slice.sv
// N-bit generate/propagate ripple carry slice: s = x + y + cin, cout = carry out.
module s_csub_slice #(
  parameter int unsigned N = 12
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/s_csub_pipe.sv
// Two-stage pipelined signed subtractor d = a - b - bi with valid/ready on both sides.
// Define S_CSUB_SAT_EN to saturate d on signed overflow (ovf/bo stay raw).
module s_csub_pipe
  import s_csub_pkg::*;
#(
  parameter int unsigned WIDTH = S_CSUB_WIDTH,
  parameter int unsigned SPLIT = S_CSUB_SPLIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int unsigned HW = WIDTH - SPLIT;

  logic             v1;
  logic             v2;
  logic             adv2;
  logic [WIDTH-1:0] nb;

  logic [SPLIT-1:0] lo_sum;
  logic             c1;
  logic [SPLIT-1:0] lo_q;
  logic             c1_q;
  logic [HW-1:0]    a_hi_q;
  logic [HW-1:0]    nb_hi_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic [HW-1:0]    hi_sum;
  logic             c2;
  logic             ovf_nxt;
  logic [WIDTH-1:0] d_nxt;

  assign nb        = ~b;
  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  s_csub_slice #(.N(SPLIT)) u_lo (
    .x    (a[SPLIT-1:0]),
    .y    (nb[SPLIT-1:0]),
    .cin  (~bi),
    .s    (lo_sum),
    .cout (c1)
  );

  s_csub_slice #(.N(HW)) u_hi (
    .x    (a_hi_q),
    .y    (nb_hi_q),
    .cin  (c1_q),
    .s    (hi_sum),
    .cout (c2)
  );

  assign ovf_nxt = (a_msb_q != b_msb_q) && (hi_sum[HW-1] != a_msb_q);

`ifdef S_CSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    d_nxt = {hi_sum, lo_q};
    if (ovf_nxt) begin
      d_nxt = a_msb_q ? SAT_LO : SAT_HI;
    end
  end
`else
  always_comb begin
    d_nxt = {hi_sum, lo_q};
  end
`endif

  // Stage 1 loads whenever it is empty or stage 2 is draining; stage 2 holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      lo_q    <= '0;
      c1_q    <= 1'b0;
      a_hi_q  <= '0;
      nb_hi_q <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d       <= '0;
      bo      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        if (in_valid) begin
          lo_q    <= lo_sum;
          c1_q    <= c1;
          a_hi_q  <= a[WIDTH-1:SPLIT];
          nb_hi_q <= nb[WIDTH-1:SPLIT];
          a_msb_q <= a[WIDTH-1];
          b_msb_q <= b[WIDTH-1];
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          d   <= d_nxt;
          bo  <= ~c2;
          ovf <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_s_csub_pipe.sv
// Directed-vector and streaming bench for s_csub_pipe (default 24/12 configuration).
module tb_s_csub_pipe;
  import s_csub_pkg::*;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bo;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  s_csub_pipe #(.WIDTH(24), .SPLIT(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_d(input logic [W-1:0] raw, input logic ov, input logic amsb);
`ifdef S_CSUB_SAT_EN
    if (ov) return amsb ? SAT_MIN : SAT_MAX;
`endif
    return raw;
  endfunction

  // Behavioural reference: {d, bo, ovf} from a wide subtraction.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbi);
    logic [W:0]   full;
    logic [W-1:0] dd;
    logic         ov;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    dd   = full[W-1:0];
    ov   = (ma[W-1] != mb[W-1]) && (dd[W-1] != ma[W-1]);
    return {exp_d(dd, ov, ma[W-1]), full[W], ov};
  endfunction

  // Called at a negedge with an empty pipeline and out_ready=1.
  task automatic apply_vec(input vec_t v, input string tag);
    a        = v.a;
    b        = v.b;
    bi       = v.bi;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1_valid"}, W'(out_valid), W'(1'b0));
    @(negedge clk);
    chk({tag, "_lat2_valid"}, W'(out_valid), W'(1'b1));
    chk({tag, "_d"}, d, exp_d(v.d, v.ovf, v.a[W-1]));
    chk({tag, "_bo"}, W'(bo), W'(v.bo));
    chk({tag, "_ovf"}, W'(ovf), W'(v.ovf));
  endtask

  logic [W+1:0] q[$];
  logic [W+1:0] e;
  logic [W-1:0] prev_d;
  logic         prev_stall;
  logic         acc;
  logic         con;
  int           sent;
  int           got;
  int           inflight;

  initial begin
    vecs[0]  = '{a: 24'h000005, b: 24'h000003, bi: 1'b0, d: 24'h000002, bo: 1'b0, ovf: 1'b0};
    vecs[1]  = '{a: 24'h000000, b: 24'h000001, bi: 1'b0, d: 24'hFFFFFF, bo: 1'b1, ovf: 1'b0};
    vecs[2]  = '{a: 24'h000010, b: 24'h000010, bi: 1'b1, d: 24'hFFFFFF, bo: 1'b1, ovf: 1'b0};
    vecs[3]  = '{a: 24'h001000, b: 24'h000001, bi: 1'b0, d: 24'h000FFF, bo: 1'b0, ovf: 1'b0};
    vecs[4]  = '{a: 24'h7FFFFF, b: 24'hFFFFFF, bi: 1'b0, d: 24'h800000, bo: 1'b1, ovf: 1'b1};
    vecs[5]  = '{a: 24'h800000, b: 24'h000001, bi: 1'b0, d: 24'h7FFFFF, bo: 1'b0, ovf: 1'b1};
    vecs[6]  = '{a: 24'h000000, b: 24'h000000, bi: 1'b1, d: 24'hFFFFFF, bo: 1'b1, ovf: 1'b0};
    vecs[7]  = '{a: 24'h000000, b: 24'h000000, bi: 1'b0, d: 24'h000000, bo: 1'b0, ovf: 1'b0};
    vecs[8]  = '{a: 24'h123456, b: 24'h023456, bi: 1'b0, d: 24'h100000, bo: 1'b0, ovf: 1'b0};
    vecs[9]  = '{a: 24'h800000, b: 24'h800000, bi: 1'b1, d: 24'hFFFFFF, bo: 1'b1, ovf: 1'b0};
    vecs[10] = '{a: 24'h800000, b: 24'h7FFFFF, bi: 1'b0, d: 24'h000001, bo: 1'b0, ovf: 1'b1};
    vecs[11] = '{a: 24'h000FFF, b: 24'hFFFFFF, bi: 1'b1, d: 24'h000FFF, bo: 1'b1, ovf: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bi        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_d", d, '0);
    chk("rst_bo", W'(bo), W'(1'b0));
    chk("rst_ovf", W'(ovf), W'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));

    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end
    repeat (2) @(negedge clk);
    chk("drain_valid", W'(out_valid), W'(1'b0));

    // Streaming with random backpressure, checked against a scoreboard.
    sent       = 0;
    got        = 0;
    inflight   = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    @(posedge clk);
    #1;
    a         = W'($urandom);
    b         = W'($urandom);
    bi        = 1'($urandom_range(0, 1));
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold_d", d, prev_d);
      chk("stream_in_ready", W'(in_ready), W'(!(inflight == 2 && !out_ready)));
      acc        = in_valid && in_ready;
      con        = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_d     = d;
      if (con) begin
        if (q.size() == 0) begin
          chk("stream_extra_beat", W'(1'b1), W'(1'b0));
        end else begin
          e = q.pop_front();
          chk("stream_d", d, e[W+1:2]);
          chk("stream_bo", W'(bo), W'(e[1]));
          chk("stream_ovf", W'(ovf), W'(e[0]));
        end
        got++;
      end
      if (acc) begin
        q.push_back(model(a, b, bi));
        sent++;
      end
      inflight = inflight + int'(acc) - int'(con);
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < 16) begin
          a  = W'($urandom);
          b  = W'($urandom);
          bi = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("stream_count", W'(got), W'(16));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Fill both stages under backpressure, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    a         = 24'h000000;
    b         = 24'h000001;
    bi        = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    a = 24'h000005;
    b = 24'h000003;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", W'(out_valid), W'(1'b1));
    chk("full_in_ready", W'(in_ready), W'(1'b0));
    chk("full_d", d, 24'hFFFFFF);
    @(negedge clk);
    chk("full_hold_d", d, 24'hFFFFFF);
    chk("full_hold_bo", W'(bo), W'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", W'(out_valid), W'(1'b0));
    chk("async_rst_d", d, '0);
    chk("async_rst_bo", W'(bo), W'(1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1'b1));
    chk("post_rst_valid", W'(out_valid), W'(1'b0));
    out_ready = 1'b1;
    apply_vec(vecs[3], "post_rst");
    @(negedge clk);
    chk("post_rst_drain", W'(out_valid), W'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
